lvt_multiport_ram: RTL and testbench



---
 rtl/lvt_multiport_ram_if.sv | 28 ++
 rtl/lvt_multiport_ram.sv | 118 +++++++++++
 tb/tb_lvt_multiport_ram.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lvt_multiport_ram_if.sv
// lvt_multiport_ram_if: write/read bus of the LVT multiport RAM
// Ports: master drives wren/wraddr/wrdata and rden/rdaddr, slave returns ready/rdvalid/rddata.
// Per-agent fields are packed, agent i at [W*i +: W].
interface lvt_multiport_ram_if #(
    parameter int NB_WRAGENT = 2,
    parameter int NB_RDAGENT = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
);
    logic                               ready;
    logic [NB_WRAGENT-1:0]              wren;
    logic [ADDR_WIDTH*NB_WRAGENT-1:0]   wraddr;
    logic [DATA_WIDTH*NB_WRAGENT-1:0]   wrdata;
    logic [NB_RDAGENT-1:0]              rden;
    logic [ADDR_WIDTH*NB_RDAGENT-1:0]   rdaddr;
    logic [NB_RDAGENT-1:0]              rdvalid;
    logic [DATA_WIDTH*NB_RDAGENT-1:0]   rddata;

    modport master (
        input  ready, rdvalid, rddata,
        output wren, wraddr, wrdata, rden, rdaddr
    );

    modport slave (
        output ready, rdvalid, rddata,
        input  wren, wraddr, wrdata, rden, rdaddr
    );
endinterface

// File: rtl/lvt_multiport_ram.sv
// lvt_multiport_ram: multi-write/multi-read RAM built from replicated banks and a live value table
// Ports: clk, rst (synchronous, active-high); bus (slave modport): ready, per-agent
//        wren/wraddr/wrdata, per-port rden/rdaddr, rdvalid/rddata one cycle after rden.
module lvt_multiport_ram #(
    parameter int NB_WRAGENT     = 2,
    parameter int NB_RDAGENT     = 2,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_DEPTH      = 2 ** ADDR_WIDTH,
    parameter int DATA_WIDTH     = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                clk,
    input logic                rst,
    lvt_multiport_ram_if.slave bus
);
    localparam int LW = NB_WRAGENT > 1 ? $clog2(NB_WRAGENT) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                           state;
    logic [ADDR_WIDTH-1:0]            cnt;
    logic                             ready;
    logic                             act;
    logic                             clearing;
    logic [ADDR_WIDTH-1:0]            wa [NB_WRAGENT];
    logic [DATA_WIDTH-1:0]            wd [NB_WRAGENT];
    logic [NB_WRAGENT-1:0]            wok;
    logic [ADDR_WIDTH-1:0]            ra [NB_RDAGENT];
    logic [NB_RDAGENT-1:0]            rok;
    logic [LW-1:0]                    lvt [RAM_DEPTH];
    logic [LW-1:0]                    sel [NB_RDAGENT];
    logic [DATA_WIDTH-1:0]            q [NB_WRAGENT][NB_RDAGENT];
    logic [NB_RDAGENT-1:0]            rdvalid;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] rddata;

    assign act      = ready & ~rst;
    assign clearing = (state == CLEAR) & ~rst;

    for (genvar w = 0; w < NB_WRAGENT; w++) begin : g_wr
        assign wa[w]  = bus.wraddr[ADDR_WIDTH*w +: ADDR_WIDTH];
        assign wd[w]  = bus.wrdata[DATA_WIDTH*w +: DATA_WIDTH];
        // out-of-range writes are dropped entirely
        assign wok[w] = act & bus.wren[w] & (32'(wa[w]) < RAM_DEPTH);
    end

    for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_ra
        assign ra[r]  = bus.rdaddr[ADDR_WIDTH*r +: ADDR_WIDTH];
        assign rok[r] = 32'(ra[r]) < RAM_DEPTH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (32'(cnt) == RAM_DEPTH - 1) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            ready <= 1'b1;
        end
    end

    // Agents are visited highest first so the lowest index lands last and wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET == 0)
                for (int i = 0; i < RAM_DEPTH; i++) lvt[i] <= '0;
        end else if (clearing) begin
            lvt[cnt] <= '0;
        end else begin
            for (int w = NB_WRAGENT - 1; w >= 0; w--)
                if (wok[w]) lvt[wa[w]] <= LW'(w);
        end
    end

    // Out-of-range reads select agent 0, whose bank register is loaded with zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdvalid <= '0;
            for (int r = 0; r < NB_RDAGENT; r++) sel[r] <= '0;
        end else begin
            rdvalid <= {NB_RDAGENT{act}} & bus.rden;
            for (int r = 0; r < NB_RDAGENT; r++)
                if (act & bus.rden[r]) sel[r] <= rok[r] ? lvt[ra[r]] : '0;
        end
    end

    for (genvar w = 0; w < NB_WRAGENT; w++) begin : g_bw
        for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_br
            logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
            logic [DATA_WIDTH-1:0] dout;
            always_ff @(posedge clk) begin
                if (clearing) mem[cnt] <= '0;
                else if (wok[w]) mem[wa[w]] <= wd[w];
            end
            always_ff @(posedge clk) begin
                if (rst) dout <= '0;
                else if (act & bus.rden[r]) dout <= rok[r] ? mem[ra[r]] : '0;
            end
            assign q[w][r] = dout;
        end
    end

    always_comb begin
        rddata = '0;
        for (int r = 0; r < NB_RDAGENT; r++)
            for (int w = 0; w < NB_WRAGENT; w++)
                if (sel[r] == LW'(w)) rddata[DATA_WIDTH*r +: DATA_WIDTH] = q[w][r];
    end

    assign bus.ready   = ready;
    assign bus.rdvalid = rdvalid;
    assign bus.rddata  = rddata;
endmodule

// File: tb/tb_lvt_multiport_ram.sv
// tb_lvt_multiport_ram: table-driven and sequence checks of lvt_multiport_ram (2 writers, 2 readers, 16x8)
module tb_lvt_multiport_ram;
    localparam int NW = 2, NR = 2, AW = 4, DEPTH = 16, DW = 8;

    typedef struct {
        logic [1:0] we;
        logic [3:0] wa0;
        logic [7:0] wd0;
        logic [3:0] wa1;
        logic [7:0] wd1;
        logic [1:0] re;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic [1:0] ev;
        logic [1:0] dm;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;
    vec_t tbl [11];

    always #5 clk = ~clk;

    lvt_multiport_ram_if #(.NB_WRAGENT(NW), .NB_RDAGENT(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    lvt_multiport_ram #(
        .NB_WRAGENT(NW), .NB_RDAGENT(NR), .ADDR_WIDTH(AW),
        .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [3:0] wa0, input logic [7:0] wd0,
                         input logic [3:0] wa1, input logic [7:0] wd1,
                         input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
        bus.wren   = we;
        bus.wraddr = {wa1, wa0};
        bus.wrdata = {wd1, wd0};
        bus.rden   = re;
        bus.rdaddr = {ra1, ra0};
    endtask

    task automatic step(input logic [1:0] we, input logic [3:0] wa0, input logic [7:0] wd0,
                        input logic [3:0] wa1, input logic [7:0] wd1,
                        input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
        @(negedge clk);
        drive(we, wa0, wd0, wa1, wd1, re, ra0, ra1);
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, flagging any rdvalid while not ready.
    task automatic wait_ready(output int cycles);
        int busy_valid;
        busy_valid = 0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (!bus.ready && bus.rdvalid != 2'b00) busy_valid++;
        end while (!bus.ready && cycles < 100);
        check("rdvalid_while_busy", busy_valid, 0);
    endtask

    initial begin
        //            we     wa0   wd0    wa1   wd1    re     ra0   ra1   ev     dm     e0     e1
        tbl[0]  = '{2'b11, 4'd3, 8'hA5, 4'd7, 8'h5A, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd7, 4'd3, 2'b11, 2'b11, 8'h5A, 8'hA5};
        tbl[2]  = '{2'b01, 4'd5, 8'h11, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[3]  = '{2'b10, 4'd0, 8'h00, 4'd5, 8'h22, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[4]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd5, 4'd5, 2'b11, 2'b11, 8'h22, 8'h22};
        tbl[5]  = '{2'b11, 4'd9, 8'h33, 4'd9, 8'h44, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 8'h00, 8'h00};
        tbl[6]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd9, 4'd9, 2'b11, 2'b11, 8'h33, 8'h33};
        tbl[7]  = '{2'b10, 4'd0, 8'h00, 4'd3, 8'hFF, 2'b01, 4'd3, 4'd0, 2'b01, 2'b01, 8'hA5, 8'h00};
        tbl[8]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd3, 4'd3, 2'b11, 2'b11, 8'hFF, 8'hFF};
        tbl[9]  = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 8'hFF, 8'hFF};
        tbl[10] = '{2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b10, 4'd0, 4'd7, 2'b10, 2'b11, 8'hFF, 8'h5A};

        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", bus.ready, 0);
        check("reset_rdvalid", bus.rdvalid, 0);
        check("reset_rddata", bus.rddata, 0);

        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        check("clear_cycles", n, 16);

        for (int i = 0; i < DEPTH; i++) begin
            step(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'(i), 4'(i));
            check($sformatf("cleared_rdvalid_%0d", i), bus.rdvalid, 2'b11);
            check($sformatf("cleared_rddata_%0d", i), bus.rddata, 16'h0000);
        end

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                 tbl[i].re, tbl[i].ra0, tbl[i].ra1);
            check($sformatf("vec%0d_rdvalid", i), bus.rdvalid, tbl[i].ev);
            if (tbl[i].dm[0]) check($sformatf("vec%0d_rddata0", i), bus.rddata[7:0], tbl[i].e0);
            if (tbl[i].dm[1]) check($sformatf("vec%0d_rddata1", i), bus.rddata[15:8], tbl[i].e1);
        end

        // Reset restarted mid-sweep, with writes and reads hammering while not ready.
        @(negedge clk);
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midsweep_ready", bus.ready, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_again_ready", bus.ready, 0);
        check("rst_again_rddata", bus.rddata, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 4'd2, 8'h77, 4'd2, 8'h77, 2'b11, 4'd2, 4'd2);
        wait_ready(n);
        drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        check("reclear_cycles", n, 16);

        step(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd2, 4'd3);
        check("reclear_rdvalid", bus.rdvalid, 2'b11);
        check("reclear_rddata", bus.rddata, 16'h0000);

        step(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0);
        check("idle_rdvalid", bus.rdvalid, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
